// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types and defaults
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MISS = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register: hold, flush-to-NOP, load
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] inst_out,
    output logic [31:0] pc4_out
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;

    // Flush only replaces the instruction; pc4 keeps its last value.
    always_comb begin
        inst_d = inst_q;
        pc4_d  = pc4_q;
        if (flush) begin
            inst_d = NOP_INST;
        end else if (load) begin
            inst_d = inst_in;
            pc4_d  = pc4_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q <= NOP_INST;
            pc4_q  <= RESET_PC;
        end else begin
            inst_q <= inst_d;
            pc4_q  <= pc4_d;
        end
    end

    assign inst_out = inst_q;
    assign pc4_out  = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with RUN/MISS/HALT control
// Optional FETCH_PERF_CNT_EN adds saturating fetch and miss-cycle counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_hit,
    input  logic        stall,
    input  logic        halted,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_ID,
    output logic [31:0] pc4_ID,
    output logic        fetch_idle
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_miss_cyc
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_flush;

    assign pc_plus4   = pc_q + 32'd4;
    assign imem_addr  = {pc_q[31:2], 2'b00};
    assign fetch_idle = (state_q == ST_HALT);

    // Priority: redirect > halted > stall > miss > normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (redirect) begin
            pc_d       = redirect_pc & ~32'h3;
            ifid_flush = 1'b1;
            state_d    = ST_RUN;
        end else if (halted || state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (!stall) begin
            if (imem_hit) begin
                pc_d      = pc_plus4;
                ifid_load = 1'b1;
                state_d   = ST_RUN;
            end else begin
                ifid_flush = 1'b1;
                state_d    = ST_MISS;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .inst_in  (imem_rdata),
        .pc4_in   (pc_plus4),
        .inst_out (inst_ID),
        .pc4_out  (pc4_ID)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_miss_cyc_q, perf_miss_cyc_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q;
        perf_miss_cyc_d = perf_miss_cyc_q;
        if (ifid_load && perf_fetched_q != 32'hFFFF_FFFF) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (state_q != ST_HALT && !imem_hit && perf_miss_cyc_q != 32'hFFFF_FFFF) begin
            perf_miss_cyc_d = perf_miss_cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q  <= 32'd0;
            perf_miss_cyc_q <= 32'd0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_miss_cyc_q <= perf_miss_cyc_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_miss_cyc = perf_miss_cyc_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_hit;
    logic        stall;
    logic        halted;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst_ID;
    logic [31:0] pc4_ID;
    logic        fetch_idle;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_miss_cyc;
`endif

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_hit    (imem_hit),
        .stall       (stall),
        .halted      (halted),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_ID     (inst_ID),
        .pc4_ID      (pc4_ID),
        .fetch_idle  (fetch_idle)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_miss_cyc (perf_miss_cyc)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: architectural PC, IF/ID contents, halted flag and counters.
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_idle;
    logic [31:0] m_fet, m_miss;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check32("inst_ID", inst_ID, m_inst);
        check32("pc4_ID", pc4_ID, m_pc4);
        check32("fetch_idle", {31'd0, fetch_idle}, {31'd0, m_idle});
`ifdef FETCH_PERF_CNT_EN
        check32("perf_fetched", perf_fetched, m_fet);
        check32("perf_miss_cyc", perf_miss_cyc, m_miss);
`endif
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_inst = NOP;
        m_pc4  = RST_PC;
        m_idle = 1'b0;
        m_fet  = 32'd0;
        m_miss = 32'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check32("imem_addr@rst", imem_addr, RST_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic h, input logic st, input logic hl, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] rdata);
        imem_hit    = h;
        stall       = st;
        halted      = hl;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = rdata;
        check32("imem_addr", imem_addr, m_pc & 32'hFFFF_FFFC);
        if (!m_idle && !h) m_miss = m_miss + 1;
        if (rd) begin
            m_pc   = rpc & 32'hFFFF_FFFC;
            m_inst = NOP;
            m_idle = 1'b0;
        end else if (hl || m_idle) begin
            m_idle = 1'b1;
        end else if (!st) begin
            if (h) begin
                m_inst = rdata;
                m_pc4  = m_pc + 32'd4;
                m_pc   = m_pc + 32'd4;
                m_fet  = m_fet + 1;
            end else begin
                m_inst = NOP;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; imem_hit = 1'b0; stall = 1'b0; halted = 1'b0;
        redirect = 1'b0; redirect_pc = '0; imem_rdata = '0;
        #2;
        do_reset();

        // Sequential fetch with rdata equal to address
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, m_pc);
        check32("seq_addr", imem_addr, 32'h0000_000C);
        check32("seq_inst", inst_ID, 32'h0000_0008);
        check32("seq_pc4", pc4_ID, 32'h0000_000C);

        // Three miss cycles at 0x10, then hit
        step(1, 0, 0, 0, 0, m_pc);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 32'hBAD0_0000);
            check32("miss_inst", inst_ID, NOP);
            check32("miss_addr", imem_addr, 32'h0000_0010);
        end
        step(1, 0, 0, 0, 0, 32'hDEAD_0010);
        check32("miss_fill", inst_ID, 32'hDEAD_0010);
        check32("miss_pc4", pc4_ID, 32'h0000_0014);

        // Redirect wins over stall
        step(1, 0, 0, 0, 0, 32'h1234_5678);
        step(1, 1, 0, 1, 32'h0000_0040, 32'h5555_5555);
        check32("redir_addr", imem_addr, 32'h0000_0040);
        check32("redir_inst", inst_ID, NOP);

        // Halt at 0x20 for 10 cycles, then resume via redirect to 0
        step(1, 0, 0, 1, 32'h0000_0020, 0);
        step(1, 0, 1, 0, 0, 32'h0000_000C);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 0, 0, $urandom);
            check32("halt_addr", imem_addr, 32'h0000_0020);
            check32("halt_idle", {31'd0, fetch_idle}, 32'd1);
        end
        step(0, 0, 0, 1, 32'h0000_0000, 0);
        step(1, 0, 0, 0, 0, 32'hCAFE_0000);
        check32("resume_inst", inst_ID, 32'hCAFE_0000);
        check32("resume_idle", {31'd0, fetch_idle}, 32'd0);

        // Wrap at top of address space (redirect low bits ignored), then reset mid-miss
        step(1, 0, 0, 1, 32'hFFFF_FFFF, 0);
        check32("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0, 32'h0BAD_F00D);
        check32("wrap_addr", imem_addr, 32'h0000_0000);
        check32("wrap_pc4", pc4_ID, 32'h0000_0000);
        step(1, 0, 0, 0, 0, 32'h1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        do_reset();
        step(1, 0, 0, 0, 0, 32'hA5A5_0000);
        check32("post_rst_inst", inst_ID, 32'hA5A5_0000);
        check32("post_rst_pc4", pc4_ID, RST_PC + 32'd4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 31) == 0,
                     $urandom_range(0, 15) == 0,
                     $urandom, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
